ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-requester arbiter and sequencer for the team's single-port RAM (shared inout data bus, registered read, `cs`/`we`/`oe` controls). It accepts independent read/write requests from two clients, grants one transaction at a time, and drives the RAM control pins cycle by cycle. It owns tristate turnaround on the shared data bus and returns read data with a valid pulse. It sits between the two datapath clients and a single RAM instance.

## Interface
- `ADDR_WIDTH`, 4: RAM address width.
- `DATA_WIDTH`, 32: RAM data width.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `req0`, `req1` input 1: request from client 0 / 1; held until the matching `gnt`.
- `we0`, `we1` input 1: 1 = write, 0 = read; held with `req`.
- `addr0`, `addr1` input ADDR_WIDTH: request address; held with `req`.
- `wdata0`, `wdata1` input DATA_WIDTH: write data; held with `req`.
- `gnt0`, `gnt1` output 1: one-cycle acceptance pulse.
- `rvalid0`, `rvalid1` output 1: one-cycle read-data-valid pulse.
- `rdata` output DATA_WIDTH: read data, shared; qualified by `rvalid0`/`rvalid1`.
- `busy` output 1: state ≠ IDLE.
- `ram_cs`, `ram_we`, `ram_oe` output 1: RAM controls.
- `ram_addr` output ADDR_WIDTH: RAM address.
- `ram_data` inout DATA_WIDTH: RAM data bus; driven only during write ACCESS, otherwise high-Z.

## Operation
- States: IDLE, ACCESS, READ.
- IDLE: `ram_cs`=`ram_we`=`ram_oe`=0. If any `req`, select winner, latch its `we`/`addr`/`wdata` into command registers, update priority, go to ACCESS. No request: stay.
- ACCESS: `ram_cs`=1, `ram_we`=latched we, `ram_oe`=0, `ram_addr`=latched addr; `ram_data`=latched wdata if write, else high-Z. `gnt` of winner = 1 this cycle only. Write → IDLE (RAM commits at end of cycle). Read → READ (RAM registers mem[addr] at end of cycle).
- READ: `ram_cs`=1, `ram_we`=0, `ram_oe`=1, same `ram_addr`; controller does not drive `ram_data`. At end of cycle capture `ram_data` into `rdata`, go to IDLE; matching `rvalid` = 1 in the following IDLE cycle.
- Arbitration: round-robin on a single last-grant bit; with both requesting, the port not granted last wins. Lone requester always wins.
- Control outputs decoded from state and command registers only; no combinational path from `req*`/`addr*` to `ram_*`.
- `rdata` holds last captured value until next read capture.
- Address passed unmodified; range checking is not this block's concern.
- Requester may change its inputs or issue a new request the cycle after `gnt`; IDLE samples it normally.

## Timing
- Write: request sampled in IDLE (cycle 0), ACCESS/gnt cycle 1, back to IDLE cycle 2. Back-to-back writes: one per 2 cycles.
- Read: IDLE cycle 0, ACCESS/gnt cycle 1, READ cycle 2, `rvalid` + `rdata` valid cycle 3 (also the next IDLE, which can accept a new request). One read per 3 cycles.
- Bus turnaround: controller and RAM never drive `ram_data` in the same cycle; write ACCESS followed by IDLE gives a dead cycle before any RAM drive.
- Reset values: state IDLE, `ram_cs`/`ram_we`/`ram_oe`=0, `ram_addr`=0, `ram_data` high-Z, `gnt*`=0, `rvalid*`=0, `rdata`=0, `busy`=0, last-grant = 1 (client 0 wins first tie).
- Reset mid-transaction: immediate clear to reset values; in-flight transaction dropped, no `gnt`/`rvalid` issued for it; requester re-requests.

## Configuration
- `RAM_ARB_FIXED_PRIO_EN` defined: fixed priority, client 0 always wins a tie; last-grant bit not implemented.
- Undefined (default): round-robin as above.

## Test plan
- Reset then `req0`=1 `we0`=1 `addr0`=3 `wdata0`=0xDEADBEEF → `gnt0` on cycle 1, `ram_cs`=`ram_we`=1, `ram_data`=0xDEADBEEF; `busy` 0 on cycle 2.
- Then `req1` read `addr1`=3 → `gnt1` cycle 1, `ram_oe`=1 cycle 2, `rvalid1`=1 and `rdata`=0xDEADBEEF cycle 3, `rvalid0` stays 0.
- `req0` and `req1` both held continuously, reads → grants alternate 0,1,0,1; with `RAM_ARB_FIXED_PRIO_EN` only `gnt0` fires.
- Write then immediate read from other client → monitor shows `ram_data` never driven by both sides (no X) in any cycle.
- Assert `rst` during READ cycle → all `ram_*` controls 0, bus high-Z same cycle, no `rvalid`; after release, new read to same address returns stored value.
- Writes to addresses 0 and 15 with 0x00000001/0x80000000, read back → exact values, no aliasing.

Source files
------------

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-client arbiter/sequencer for a single-port registered-read RAM
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority (client 0 wins ties); default is round-robin.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, READ} state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  sel_q, sel_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rvalid0_q, rvalid0_d;
  logic                  rvalid1_q, rvalid1_d;
  logic                  pick1;
`ifndef RAM_ARB_FIXED_PRIO_EN
  logic                  last_q, last_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sel_q     <= 1'b0;
      rdata_q   <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      rdata_q   <= rdata_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
`ifndef RAM_ARB_FIXED_PRIO_EN
      last_q    <= last_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    rdata_d   = rdata_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
`ifdef RAM_ARB_FIXED_PRIO_EN
    pick1     = req1 & ~req0;
`else
    last_d    = last_q;
    // On a tie the client that was not granted last wins.
    pick1     = req1 & (~req0 | ~last_q);
`endif
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          sel_d   = pick1;
          we_d    = pick1 ? we1 : we0;
          addr_d  = pick1 ? addr1 : addr0;
          wdata_d = pick1 ? wdata1 : wdata0;
          state_d = ACCESS;
`ifndef RAM_ARB_FIXED_PRIO_EN
          last_d  = pick1;
`endif
        end
      end
      ACCESS: state_d = we_q ? IDLE : READ;
      READ: begin
        rdata_d   = ram_data;
        rvalid0_d = ~sel_q;
        rvalid1_d = sel_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign ram_cs   = (state_q != IDLE);
  assign ram_we   = (state_q == ACCESS) & we_q;
  assign ram_oe   = (state_q == READ);
  assign ram_addr = addr_q;
  assign gnt0     = (state_q == ACCESS) & ~sel_q;
  assign gnt1     = (state_q == ACCESS) & sel_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign rdata    = rdata_q;
  // Only the write ACCESS cycle drives the bus; the RAM drives only while ram_oe.
  assign ram_data = (state_q == ACCESS && we_q) ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed table-driven bench for ram_arbiter with a registered-read RAM model
module tb_ram_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [3:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, busy, ram_cs, ram_we, ram_oe;
  logic [31:0] rdata;
  logic [3:0]  ram_addr;
  wire  [31:0] ram_data;

  logic [31:0] mem [16];
  logic [31:0] mem_rd_q;

  int total = 0;
  int bad = 0;
  int conflicts = 0;
  logic [31:0] last_rdata;

  ram_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_addr(ram_addr), .ram_data(ram_data)
  );

  always #5 clk = ~clk;

  // RAM model: write commits at clock edge, read registers during the ACCESS cycle.
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_addr] <= ram_data;
    else if (ram_cs && !ram_oe) mem_rd_q <= mem[ram_addr];
  end
  assign ram_data = ram_oe ? mem_rd_q : 32'hzzzz_zzzz;

  always @(negedge clk) begin
    if (ram_oe && ram_we) conflicts = conflicts + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        client;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic run_txn(input vec_t v);
    if (v.client) begin
      req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    end
    @(negedge clk);
    chk("gnt0", {31'b0, gnt0}, {31'b0, ~v.client});
    chk("gnt1", {31'b0, gnt1}, {31'b0, v.client});
    chk("acc_cs_we_oe", {29'b0, ram_cs, ram_we, ram_oe}, {29'b0, 1'b1, v.we, 1'b0});
    chk("acc_addr", {28'b0, ram_addr}, {28'b0, v.addr});
    if (v.we) chk("acc_wdata", ram_data, v.wdata);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    if (v.we) begin
      chk("wr_busy_done", {31'b0, busy}, 32'd0);
      chk("wr_idle_ctl", {29'b0, ram_cs, ram_we, ram_oe}, 32'd0);
      chk("wr_rdata_hold", rdata, last_rdata);
    end else begin
      chk("rd_ctl", {29'b0, ram_cs, ram_we, ram_oe}, 32'b101);
      chk("rd_addr", {28'b0, ram_addr}, {28'b0, v.addr});
      @(negedge clk);
      chk("rvalid", {30'b0, rvalid1, rvalid0}, v.client ? 32'b10 : 32'b01);
      chk("rdata", rdata, v.exp_rdata);
      chk("rd_busy_done", {31'b0, busy}, 32'd0);
      last_rdata = v.exp_rdata;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_rdata = 32'd0;
  endtask

  vec_t vecs [8];
  logic [1:0] gseq [12];
  logic [1:0] gexp [12];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 4'd3,  32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 4'd3,  32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b0, 1'b1, 4'd0,  32'h00000001, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 4'd15, 32'h80000000, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 4'd0,  32'h12345678, 32'h00000001};
    vecs[5] = '{1'b1, 1'b0, 4'd15, 32'h0,        32'h80000000};
    vecs[6] = '{1'b1, 1'b1, 4'd5,  32'hA5A5A5A5, 32'h0};
    vecs[7] = '{1'b0, 1'b0, 4'd5,  32'h5A5A5A5A, 32'hA5A5A5A5};

    do_reset();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ctl", {29'b0, ram_cs, ram_we, ram_oe}, 32'd0);
    chk("rst_addr", {28'b0, ram_addr}, 32'd0);
    chk("rst_busy_gnt_rv", {27'b0, busy, gnt0, gnt1, rvalid0, rvalid1}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);
    chk("bus_conflicts", conflicts, 32'd0);

    // Reset asserted in the READ cycle drops the read.
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd3;
    @(negedge clk);
    chk("pre_rst_gnt1", {31'b0, gnt1}, 32'd1);
    @(posedge clk); #1;
    req1 = 1'b0;
    chk("pre_rst_oe", {31'b0, ram_oe}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_ctl", {29'b0, ram_cs, ram_we, ram_oe}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_no_rvalid", {30'b0, rvalid1, rvalid0}, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    last_rdata = 32'd0;
    run_txn('{1'b1, 1'b0, 4'd3, 32'h0, 32'hDEADBEEF});

    // Both clients hold read requests continuously.
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'd2;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      gseq[c] = {gnt1, gnt0};
      gexp[c] = 2'b00;
    end
`ifdef RAM_ARB_FIXED_PRIO_EN
    gexp[0] = 2'b01; gexp[3] = 2'b01; gexp[6] = 2'b01; gexp[9] = 2'b01;
`else
    gexp[0] = 2'b01; gexp[3] = 2'b10; gexp[6] = 2'b01; gexp[9] = 2'b10;
`endif
    for (int c = 0; c < 12; c++) chk($sformatf("arb_cycle%0d", c), {30'b0, gseq[c]}, {30'b0, gexp[c]});
    req0 = 1'b0; req1 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
